// File: rtl/lsu_unit_if.sv
// Data-memory request/acknowledge port between the load/store unit and memory.
// The master drives the request side; the slave returns read data and ack.
interface lsu_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_unit.sv
// RV32I load/store unit: one data-memory transaction per load/store strobe,
// stalling the core until ack, error or timeout, then pulsing done.
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  fun3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  lsu_unit_if.master  mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] load_data_q, load_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  fun3_q, fun3_d;
  logic [1:0]  off_q, off_d;

  logic        illegal;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Lane extraction uses the registered offset/size so it does not depend on
  // the core keeping its inputs stable past the ack cycle.
  always_comb begin
    byte_sel = 8'h00;
    case (off_q)
      2'd0: byte_sel = mem.mem_rdata[7:0];
      2'd1: byte_sel = mem.mem_rdata[15:8];
      2'd2: byte_sel = mem.mem_rdata[23:16];
      2'd3: byte_sel = mem.mem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (fun3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    illegal    = (load & store)
               | (load & ((fun3 == 3'b011) | (fun3[2:1] == 2'b11)))
               | (store & (fun3 >= 3'b011));
    misaligned = ((fun3[1:0] == 2'b01) & addr[0])
               | ((fun3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    load_data_d = load_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    fun3_d      = fun3_q;
    off_d       = off_q;

    case (state_q)
      IDLE: begin
        if (load | store) begin
          if (illegal | misaligned) begin
            state_d     = DONE;
            done_d      = 1'b1;
            err_d       = 1'b1;
            load_data_d = 32'h0;
          end else begin
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = store;
            mem_addr_d  = {addr[31:2], 2'b00};
            fun3_d      = fun3;
            off_d       = addr[1:0];
            cnt_d       = 8'd0;
            mem_wstrb_d = 4'b0000;
            mem_wdata_d = 32'h0;
            if (store) begin
              case (fun3[1:0])
                2'b00: begin
                  mem_wdata_d = {4{store_data[7:0]}};
                  mem_wstrb_d = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                  mem_wdata_d = {2{store_data[15:0]}};
                  mem_wstrb_d = 4'b0011 << {addr[1], 1'b0};
                end
                default: begin
                  mem_wdata_d = store_data;
                  mem_wstrb_d = 4'b1111;
                end
              endcase
            end
          end
        end
      end
      BUSY: begin
        // An ack in the expiry cycle completes normally.
        if (mem.mem_ack) begin
          state_d     = DONE;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          load_data_d = mem_we_q ? 32'h0 : load_ext;
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d     = DONE;
          done_d      = 1'b1;
          err_d       = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          load_data_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      load_data_q <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
      fun3_q      <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      load_data_q <= load_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      fun3_q      <= fun3_d;
      off_q       <= off_d;
    end
  end

  assign stall         = ((state_q == IDLE) & (load | store)) | (state_q == BUSY);
  assign done          = done_q;
  assign err           = err_q;
  assign load_data     = load_data_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: expected results are queued when a request is
// driven and compared when done pulses.
module tb_lsu_unit;
  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        store;
  logic [2:0]  fun3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] load_data;

  lsu_unit_if mif ();

  lsu_unit #(.TIMEOUT_CYC(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .store      (store),
    .fun3       (fun3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .err        (err),
    .load_data  (load_data),
    .mem        (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] ld;
    logic        err;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic        we;
    int          req;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: classification, lane placement and load extension.
  function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int ack_at);
    exp_t        e;
    logic        bad;
    logic [31:0] sh;
    bad = 1'b0;
    if (ld && st) bad = 1'b1;
    if (ld && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) bad = 1'b1;
    if (st && !(f3 inside {3'b000, 3'b001, 3'b010})) bad = 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) bad = 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1'b1;
    e.addr = {a[31:2], 2'b00};
    e.we   = st;
    e.strb = 4'b0000;
    e.wd   = 32'h0;
    if (st) begin
      if (f3 == 3'b000) begin e.wd = {4{sd[7:0]}};  e.strb = 4'b0001 << a[1:0]; end
      if (f3 == 3'b001) begin e.wd = {2{sd[15:0]}}; e.strb = a[1] ? 4'b1100 : 4'b0011; end
      if (f3 == 3'b010) begin e.wd = sd;            e.strb = 4'b1111; end
    end
    sh = rd >> {a[1:0], 3'b000};
    case (f3)
      3'b000:  e.ld = {{24{sh[7]}}, sh[7:0]};
      3'b001:  e.ld = {{16{sh[15]}}, sh[15:0]};
      3'b100:  e.ld = {24'h0, sh[7:0]};
      3'b101:  e.ld = {16'h0, sh[15:0]};
      default: e.ld = rd;
    endcase
    if (bad) begin
      e.req = 0;
      e.err = 1'b1;
    end else if (ack_at >= 1 && ack_at <= T) begin
      e.req = ack_at;
      e.err = 1'b0;
      if (st) e.ld = 32'h0;
    end else begin
      e.req = T;
      e.err = 1'b1;
      e.ld  = 32'h0;
    end
    return e;
  endfunction

  // ack_at: BUSY cycle (1-based) in which ack is given; 0 = never.
  task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int ack_at);
    exp_t e;
    int   req_cnt;
    bit   got;
    bit   first;
    sb_q.push_back(model(ld, st, f3, a, sd, rd, ack_at));
    @(negedge clk);
    load = ld; store = st; fun3 = f3; addr = a; store_data = sd;
    mif.mem_rdata = rd; mif.mem_ack = 1'b0;
    #1 chk("stall_c0", {31'h0, stall}, 32'h1);
    req_cnt = 0; got = 1'b0; first = 1'b1;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
      if (mif.mem_req) begin
        req_cnt++;
        if (first) begin
          first = 1'b0;
          e = sb_q[0];
          chk("mem_addr", mif.mem_addr, e.addr);
          chk("mem_we", {31'h0, mif.mem_we}, {31'h0, e.we});
          chk("mem_wstrb", {28'h0, mif.mem_wstrb}, {28'h0, e.strb});
          if (st) chk("mem_wdata", mif.mem_wdata, e.wd);
        end
        if (req_cnt == ack_at) mif.mem_ack = 1'b1;
      end
      if (done) begin
        got = 1'b1;
        e = sb_q.pop_front();
        chk("done_cycle", c, e.req + 1);
        chk("req_cycles", req_cnt, e.req);
        chk("err", {31'h0, err}, {31'h0, e.err});
        if (ld && !st && e.req > 0) chk("load_data", load_data, e.ld);
        chk("stall_done", {31'h0, stall}, 32'h0);
        $display("txn ld=%0b st=%0b f3=%03b addr=%h ack_at=%0d -> done@%0d err=%0b load_data=%h",
                 ld, st, f3, a, ack_at, c, err, load_data);
        load = 1'b0; store = 1'b0;
      end
    end
    chk("done_seen", {31'h0, got}, 32'h1);
    if (!got) void'(sb_q.pop_front());
    @(posedge clk); #1;
    chk("done_pulse", {31'h0, done}, 32'h0);
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; load = 1'b0; store = 1'b0; fun3 = 3'b000;
    addr = 32'h0; store_data = 32'h0;
    mif.mem_rdata = 32'h0; mif.mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'h0, mif.mem_req}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_wstrb", {28'h0, mif.mem_wstrb}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    run_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 1);  // lb
    run_txn(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 2);  // lhu
    run_txn(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);  // lh
    run_txn(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_F056, 3);  // lbu
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hDEAD_BEEF, 1);  // lw
    run_txn(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'hAAAA_BEEF, 32'h0, 1);  // sh
    run_txn(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'hAAAA_BEEF, 32'h0, 2);  // sb
    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_3008, 32'h1357_9BDF, 32'h0, 1);  // sw
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 1);          // misaligned lw
    run_txn(1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 1);          // load&store
    run_txn(1'b0, 1'b1, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 1);          // illegal store
    run_txn(1'b1, 1'b0, 3'b110, 32'h0000_4000, 32'h0, 32'h0, 1);          // illegal load
    run_txn(1'b1, 1'b0, 3'b001, 32'h0000_4001, 32'h0, 32'h0, 1);          // misaligned lh
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h1111_2222, 0);  // timeout
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h1111_2222, T);  // ack on expiry
    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_6004, 32'hCAFE_F00D, 32'h0, 0);  // store timeout

    // Reset in the middle of BUSY, then a stray ack after release.
    @(negedge clk);
    load = 1'b1; store = 1'b0; fun3 = 3'b010; addr = 32'h0000_5000;
    mif.mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_mem_req", {31'h0, mif.mem_req}, 32'h1);
    rst_n = 1'b0; load = 1'b0;
    #1;
    chk("async_mem_req", {31'h0, mif.mem_req}, 32'h0);
    chk("async_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; mif.mem_ack = 1'b1;
    done_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    mif.mem_ack = 1'b0;
    chk("late_ack_done", done_seen, 0);
    chk("late_ack_req", {31'h0, mif.mem_req}, 32'h0);
    $display("txn reset mid-BUSY, late ack -> done pulses %0d", done_seen);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
